// File: rtl/flash_pad_arbiter.sv
// flash_pad_arbiter: hands the QSPI flash pads between the core flash controller and a pass-through port.
// Define FLASH_ARB_TIMEOUT_EN to abort a DRAIN that the core never lets finish.
module flash_pad_arbiter #(
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       core_clk,
  input  logic       core_rst,
  input  logic       core_csb,
  input  logic       core_sck,
  input  logic [3:0] core_io_do,
  input  logic [3:0] core_io_oeb,
  output logic [3:0] core_io_di,
  output logic       core_hold,
  input  logic       pt_req,
  output logic       pt_gnt,
  input  logic       pt_csb,
  input  logic       pt_sck,
  input  logic [3:0] pt_io_do,
  input  logic [3:0] pt_io_oeb,
  output logic [3:0] pt_io_di,
  output logic       flash_csb,
  output logic       flash_clk,
  output logic [3:0] flash_io_do,
  output logic [3:0] flash_io_oeb,
  input  logic [3:0] flash_io_di,
  output logic       arb_err
);
  localparam int MAXP = GUARD_CYCLES > TIMEOUT_CYCLES ? GUARD_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXP) + 1;
  typedef enum logic [1:0] {CORE, DRAIN, PT, RELEASE} state_t;
  state_t        state_q;
  logic [CW-1:0] gcnt_q;
  logic          pt_gnt_q, core_hold_q, arb_err_q;
  logic          tmo, blk;
`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tcnt_q;
  logic          blk_q;
  assign tmo = state_q == DRAIN && pt_req && !core_csb && tcnt_q == TW'(TIMEOUT_CYCLES - 1);
  assign blk = blk_q;
  // After an abort the request must be withdrawn before another DRAIN is allowed.
  always_ff @(posedge core_clk or posedge core_rst)
    if (core_rst) begin
      tcnt_q <= '0;
      blk_q  <= 1'b0;
    end else begin
      tcnt_q <= state_q != DRAIN ? '0 : tcnt_q + TW'(!core_csb);
      blk_q  <= tmo ? 1'b1 : (pt_req ? blk_q : 1'b0);
    end
`else
  assign tmo = 1'b0;
  assign blk = 1'b0;
`endif
  always_ff @(posedge core_clk or posedge core_rst)
    if (core_rst) begin
      state_q     <= CORE;
      gcnt_q      <= '0;
      pt_gnt_q    <= 1'b0;
      core_hold_q <= 1'b0;
      arb_err_q   <= 1'b0;
    end else begin
      arb_err_q <= tmo;
      case (state_q)
        CORE:
          if (pt_req && !blk) begin
            state_q     <= DRAIN;
            gcnt_q      <= CW'(GUARD_CYCLES);
            core_hold_q <= 1'b1;
          end
        DRAIN:
          if (!pt_req || tmo) begin
            state_q     <= CORE;
            core_hold_q <= 1'b0;
          end else if (!core_csb) begin
            gcnt_q <= CW'(GUARD_CYCLES);
          end else if (gcnt_q == CW'(1)) begin
            state_q  <= PT;
            pt_gnt_q <= 1'b1;
          end else begin
            gcnt_q <= gcnt_q - CW'(1);
          end
        PT:
          if (!pt_req) begin
            state_q  <= RELEASE;
            pt_gnt_q <= 1'b0;
            gcnt_q   <= CW'(GUARD_CYCLES);
          end
        default:
          if (gcnt_q == CW'(1)) begin
            state_q     <= CORE;
            core_hold_q <= 1'b0;
          end else begin
            gcnt_q <= gcnt_q - CW'(1);
          end
      endcase
    end
  logic idle, own_pt;
  assign idle         = state_q == DRAIN || state_q == RELEASE;
  assign own_pt       = state_q == PT;
  assign flash_csb    = idle ? 1'b1  : own_pt ? pt_csb    : core_csb;
  assign flash_clk    = idle ? 1'b0  : own_pt ? pt_sck    : core_sck;
  assign flash_io_do  = idle ? 4'h0  : own_pt ? pt_io_do  : core_io_do;
  assign flash_io_oeb = idle ? 4'hF  : own_pt ? pt_io_oeb : core_io_oeb;
  assign core_io_di   = flash_io_di;
  assign pt_io_di     = flash_io_di;
  assign pt_gnt       = pt_gnt_q;
  assign core_hold    = core_hold_q;
  assign arb_err      = arb_err_q;
endmodule

// File: tb/tb_flash_pad_arbiter.sv
// tb_flash_pad_arbiter: directed checks of ownership handover, guard timing, reset and optional DRAIN timeout.
module tb_flash_pad_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic       core_csb, core_sck, pt_req, pt_csb, pt_sck;
  logic [3:0] core_io_do, core_io_oeb, pt_io_do, pt_io_oeb, flash_io_di;
  logic [3:0] core_io_di, pt_io_di, flash_io_do, flash_io_oeb;
  logic       core_hold, pt_gnt, flash_csb, flash_clk, arb_err;
  int         checks = 0, errors = 0;
  flash_pad_arbiter #(.GUARD_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .core_clk(clk), .core_rst(rst), .core_csb(core_csb), .core_sck(core_sck),
    .core_io_do(core_io_do), .core_io_oeb(core_io_oeb), .core_io_di(core_io_di),
    .core_hold(core_hold), .pt_req(pt_req), .pt_gnt(pt_gnt), .pt_csb(pt_csb),
    .pt_sck(pt_sck), .pt_io_do(pt_io_do), .pt_io_oeb(pt_io_oeb), .pt_io_di(pt_io_di),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io_do(flash_io_do),
    .flash_io_oeb(flash_io_oeb), .flash_io_di(flash_io_di), .arb_err(arb_err));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic pads(input string tag, input logic csb, input logic sck, input logic [3:0] dout, input logic [3:0] oeb);
    #1;
    chk({tag, "_csb"}, {7'd0, flash_csb}, {7'd0, csb});
    chk({tag, "_clk"}, {7'd0, flash_clk}, {7'd0, sck});
    chk({tag, "_do"}, {4'd0, flash_io_do}, {4'd0, dout});
    chk({tag, "_oeb"}, {4'd0, flash_io_oeb}, {4'd0, oeb});
  endtask
  task automatic ctl(input string tag, input logic gnt, input logic hold, input logic err);
    chk({tag, "_gnt"}, {7'd0, pt_gnt}, {7'd0, gnt});
    chk({tag, "_hold"}, {7'd0, core_hold}, {7'd0, hold});
    chk({tag, "_err"}, {7'd0, arb_err}, {7'd0, err});
  endtask
  initial begin
    core_csb = 1'b0; core_sck = 1'b0; core_io_do = 4'hA; core_io_oeb = 4'h0;
    pt_req = 1'b0; pt_csb = 1'b1; pt_sck = 1'b0; pt_io_do = 4'h0; pt_io_oeb = 4'hF;
    flash_io_di = 4'h3;
    #1;
    ctl("rst", 1'b0, 1'b0, 1'b0);
    pads("rst", 1'b0, 1'b0, 4'hA, 4'h0);
    chk("di_core", {4'd0, core_io_di}, 8'h03);
    chk("di_pt", {4'd0, pt_io_di}, 8'h03);
    tick(2);
    rst = 1'b0;
    tick(1);
    core_sck = 1'b1;
    pads("idle_sck1", 1'b0, 1'b1, 4'hA, 4'h0);
    core_sck = 1'b0; core_io_oeb = 4'h6;
    pads("idle_sck0", 1'b0, 1'b0, 4'hA, 4'h6);
    ctl("idle", 1'b0, 1'b0, 1'b0);
    // Request with core idle: hold one cycle later, grant GUARD_CYCLES after that.
    core_csb = 1'b1; core_io_oeb = 4'h0;
    tick(1);
    pt_req = 1'b1;
    tick(1);
    core_sck = 1'b1;
    ctl("drain1", 1'b0, 1'b1, 1'b0);
    pads("drain1", 1'b1, 1'b0, 4'h0, 4'hF);
    tick(3);
    ctl("drain4", 1'b0, 1'b1, 1'b0);
    tick(1);
    ctl("pt", 1'b1, 1'b1, 1'b0);
    pt_csb = 1'b0; pt_io_do = 4'h5; pt_io_oeb = 4'h0; pt_sck = 1'b1;
    pads("pt", 1'b0, 1'b1, 4'h5, 4'h0);
    flash_io_di = 4'hC;
    chk("pt_di", {4'd0, pt_io_di}, 8'h0C);
    // Release, then re-request inside the guard gap.
    pt_req = 1'b0;
    tick(1);
    ctl("rel1", 1'b0, 1'b1, 1'b0);
    pads("rel1", 1'b1, 1'b0, 4'h0, 4'hF);
    pt_req = 1'b1;
    tick(3);
    ctl("rel4", 1'b0, 1'b1, 1'b0);
    tick(1);
    core_sck = 1'b0;
    ctl("fair_core", 1'b0, 1'b0, 1'b0);
    pads("fair_core", 1'b1, 1'b0, 4'hA, 4'h0);
    tick(1);
    ctl("redrain", 1'b0, 1'b1, 1'b0);
    // Core busy: no grant; a csb-low glitch restarts the guard count.
    core_csb = 1'b0;
    tick(10);
    ctl("busy10", 1'b0, 1'b1, 1'b0);
    pads("busy10", 1'b1, 1'b0, 4'h0, 4'hF);
    core_csb = 1'b1;
    tick(2);
    core_csb = 1'b0;
    tick(1);
    core_csb = 1'b1;
    tick(3);
    ctl("glitch3", 1'b0, 1'b1, 1'b0);
    tick(1);
    ctl("glitch_gnt", 1'b1, 1'b1, 1'b0);
    // Asynchronous reset mid-session hands the pads back at once.
    core_csb = 1'b0; core_io_do = 4'h9;
    rst = 1'b1;
    #1;
    ctl("arst", 1'b0, 1'b0, 1'b0);
    pads("arst", 1'b0, 1'b0, 4'h9, 4'h0);
    pt_req = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    ctl("post_rst", 1'b0, 1'b0, 1'b0);
    // DRAIN against a core that never releases csb.
    pt_req = 1'b1;
    tick(1);
    tick(15);
    ctl("drain16", 1'b0, 1'b1, 1'b0);
`ifdef FLASH_ARB_TIMEOUT_EN
    tick(1);
    ctl("tmo", 1'b0, 1'b0, 1'b1);
    pads("tmo", 1'b0, 1'b0, 4'h9, 4'h0);
    tick(1);
    ctl("tmo_after", 1'b0, 1'b0, 1'b0);
    tick(3);
    ctl("tmo_blocked", 1'b0, 1'b0, 1'b0);
    pt_req = 1'b0;
    tick(1);
    pt_req = 1'b1;
    tick(1);
    ctl("retry", 1'b0, 1'b1, 1'b0);
`else
    tick(20);
    ctl("no_tmo", 1'b0, 1'b1, 1'b0);
    pads("no_tmo", 1'b1, 1'b0, 4'h0, 4'hF);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
